// File: rtl/pkt_pkg.sv
// -----------------------------------------------------------------------------
// pkt_pkg
// Shared definitions for the Send/Ack packet pipeline receiver.
//   PKT_W        packet width (38 bits)
//   *_MSB/*_LSB  field positions inside a packet:
//                hdr[37:27] dest[26:20] lr[19] flag[18] data[17:0]
//   rx_state_t   handshake FSM states (IDLE, ACKED, RELEASE)
// -----------------------------------------------------------------------------
package pkt_pkg;

    localparam int PKT_W    = 38;

    localparam int HDR_MSB  = 37;
    localparam int HDR_LSB  = 27;
    localparam int DEST_MSB = 26;
    localparam int DEST_LSB = 20;
    localparam int LR_MSB   = 19;
    localparam int LR_LSB   = 19;
    localparam int FLAG_MSB = 18;
    localparam int FLAG_LSB = 18;
    localparam int DATA_MSB = 17;
    localparam int DATA_LSB = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACKED   = 2'd1,
        RELEASE = 2'd2
    } rx_state_t;

endpackage

// File: rtl/pkt_rx_stage_if.sv
// -----------------------------------------------------------------------------
// pkt_rx_stage_if
// Bundles the upstream four-phase handshake and the downstream valid/ready
// port of pkt_rx_stage.
//   Send_in / PACKET_IN / Ack_out          bundled-data handshake (upstream)
//   rx_valid / rx_ready / rx_hdr .. rx_data decoded head-of-FIFO (downstream)
// Modports:
//   slave  - the receiver (pkt_rx_stage)
//   master - the environment around it (upstream sender + consumer)
// -----------------------------------------------------------------------------
interface pkt_rx_stage_if;
    import pkt_pkg::*;

    logic             Send_in;
    logic [PKT_W-1:0] PACKET_IN;
    logic             Ack_out;

    logic             rx_valid;
    logic             rx_ready;
    logic [10:0]      rx_hdr;
    logic [6:0]       rx_dest;
    logic             rx_lr;
    logic             rx_flag;
    logic [17:0]      rx_data;

    modport slave (
        input  Send_in, PACKET_IN, rx_ready,
        output Ack_out, rx_valid, rx_hdr, rx_dest, rx_lr, rx_flag, rx_data
    );

    modport master (
        output Send_in, PACKET_IN, rx_ready,
        input  Ack_out, rx_valid, rx_hdr, rx_dest, rx_lr, rx_flag, rx_data
    );

endinterface

// File: rtl/pkt_rx_fifo.sv
// -----------------------------------------------------------------------------
// pkt_rx_fifo
// Small synchronous FIFO with first-word visibility on dout (no fall-through:
// a written entry becomes visible the cycle after the write).
//   CLK, MR_n   clock and asynchronous active-low reset
//   push, din   write request and data (ignored while full)
//   pop         read request (ignored while empty)
//   full, empty status flags
//   dout        head entry; holds the last value of that slot while empty
// -----------------------------------------------------------------------------
module pkt_rx_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             MR_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the
    // address bits coincide.
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];

    logic wr_en;
    logic rd_en;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // Full/empty are judged on the current pointers, so a pop never makes
    // room for a push in the same cycle.
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    assign dout = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage is cleared on reset so the decoded outputs read 0 afterwards.
    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/pkt_rx_stage.sv
// -----------------------------------------------------------------------------
// pkt_rx_stage
// Clocked terminator of the self-timed Send/Ack packet pipeline. Synchronises
// Send_in, runs the four-phase handshake, buffers packets in pkt_rx_fifo and
// presents the head entry split into fields on a valid/ready port.
//   CLK       system clock, rising edge
//   MR_n      master reset, asynchronous assert, active-low
//   bus       pkt_rx_stage_if.slave (Send_in/PACKET_IN/Ack_out, rx_*)
// Optional (macro PKT_RX_STATS_EN):
//   rx_count  16-bit count of FIFO pushes, wraps
//   rx_stall  registered: IDLE with request pending while FIFO full
// Parameters:
//   FIFO_DEPTH   buffer entries (power of two, >= 2)
//   SYNC_STAGES  Send_in synchroniser length (>= 2)
// -----------------------------------------------------------------------------
module pkt_rx_stage
    import pkt_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                CLK,
    input  logic                MR_n,
    pkt_rx_stage_if.slave       bus
`ifdef PKT_RX_STATS_EN
    ,
    output logic [15:0]         rx_count,
    output logic                rx_stall
`endif
);

    // ---------------- Send_in synchroniser ----------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   req_s;

    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) sync_reg <= '0;
        else       sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.Send_in};
    end

    assign req_s = sync_reg[SYNC_STAGES-1];

    // ---------------- handshake FSM ----------------
    rx_state_t state_reg;
    rx_state_t state_next;

    logic             fifo_full;
    logic             fifo_empty;
    logic [PKT_W-1:0] fifo_dout;

    logic             capture;
    logic             ack_next;
    logic             ack_reg;
    logic             hold_valid_reg;
    logic [PKT_W-1:0] hold_reg;
    logic             push_accept;

    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_s && !fifo_full) state_next = ACKED;
            ACKED:   if (!req_s)              state_next = RELEASE;
            // Guard cycle: lets the synchroniser settle so the previous
            // request's high level cannot start a second capture.
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        capture  = (state_reg == IDLE) && req_s && !fifo_full;
        ack_next = (state_next == ACKED);
    end

    // PACKET_IN is sampled into a holding register on the IDLE->ACKED edge
    // and written to the FIFO on the following edge. The next capture can
    // only happen after ACKED and RELEASE, so the held packet always lands
    // before the full flag is consulted again.
    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            ack_reg        <= 1'b0;
            hold_valid_reg <= 1'b0;
            hold_reg       <= '0;
        end else begin
            ack_reg        <= ack_next;
            hold_valid_reg <= capture;
            if (capture) hold_reg <= bus.PACKET_IN;
        end
    end

    assign push_accept = hold_valid_reg && !fifo_full;
    assign bus.Ack_out = ack_reg;

    // ---------------- buffer ----------------
    pkt_rx_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .MR_n  (MR_n),
        .push  (hold_valid_reg),
        .din   (hold_reg),
        .pop   (bus.rx_ready),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    // ---------------- decoded head ----------------
    assign bus.rx_valid = !fifo_empty;
    assign bus.rx_hdr   = fifo_dout[HDR_MSB:HDR_LSB];
    assign bus.rx_dest  = fifo_dout[DEST_MSB:DEST_LSB];
    assign bus.rx_lr    = fifo_dout[LR_MSB];
    assign bus.rx_flag  = fifo_dout[FLAG_MSB];
    assign bus.rx_data  = fifo_dout[DATA_MSB:DATA_LSB];

`ifdef PKT_RX_STATS_EN
    // ---------------- statistics ----------------
    logic [15:0] rx_count_reg;
    logic        rx_stall_reg;

    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            rx_count_reg <= '0;
            rx_stall_reg <= 1'b0;
        end else begin
            if (push_accept) rx_count_reg <= rx_count_reg + 16'd1;
            rx_stall_reg <= (state_reg == IDLE) && req_s && fifo_full;
        end
    end

    assign rx_count = rx_count_reg;
    assign rx_stall = rx_stall_reg;
`else
    // Push acceptance only feeds the statistics block.
    logic unused_push_accept;
    assign unused_push_accept = push_accept;
`endif

endmodule
